pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection FSM with misaligned-target trap, epc capture and retire counter
// BOOT issues the reset vector, RUN selects halt > stall > jump > branch > pc+4, HALT holds until resume.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] PCNext,
    output logic        pc_en,
    output logic [1:0]  state,
    output logic        trap,
    output logic [31:0] epc,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'b00,
        S_RUN    = 2'b01,
        S_HALT   = 2'b10,
        S_UNUSED = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic        trap_q, trap_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] target;
    logic        redirect;
    logic        misaligned;

    assign redirect   = jump | branch_taken;
    assign target     = jump ? jump_target : branch_target;
    assign misaligned = (target[1:0] != 2'b00);

    always_comb begin
        PCNext    = pc;
        pc_en     = 1'b0;
        state_d   = state_q;
        trap_d    = 1'b0;
        epc_d     = epc_q;
        case (state_q)
            S_RUN: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (!stall) begin
                    pc_en = 1'b1;
                    if (redirect && misaligned) begin
                        PCNext = TRAP_VEC;
                        trap_d = 1'b1;
                        epc_d  = pc;
                    end else if (redirect) begin
                        PCNext = target;
                    end else begin
                        PCNext = pc + 32'd4;
                    end
                end
            end
            S_HALT: begin
                if (resume && !halt_req) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                // Unused encoding 11 behaves exactly like BOOT
                PCNext  = RESET_VEC;
                pc_en   = 1'b1;
                state_d = S_RUN;
            end
        endcase
        instret_d = (state_q == S_RUN && pc_en) ? instret_q + 32'd1 : instret_q;
        if (rst) begin
            PCNext    = RESET_VEC;
            pc_en     = 1'b1;
            state_d   = S_BOOT;
            trap_d    = 1'b0;
            epc_d     = 32'd0;
            instret_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        trap_q    <= trap_d;
        epc_q     <= epc_d;
        instret_q <= instret_d;
    end

    assign state   = state_q;
    assign trap    = trap_q;
    assign epc     = epc_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - vector table, directed corner sequences and randomized run against a reference model
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        stall, branch_taken, jump, halt_req, resume;
    logic [31:0] branch_target, jump_target;
    logic [31:0] PCNext;
    logic        pc_en;
    logic [1:0]  state;
    logic        trap;
    logic [31:0] epc, instret;

    pc_sequencer #(.RESET_VEC(RV), .TRAP_VEC(TV)) dut (
        .clk(clk), .rst(rst), .pc(pc), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .halt_req(halt_req), .resume(resume),
        .PCNext(PCNext), .pc_en(pc_en), .state(state),
        .trap(trap), .epc(epc), .instret(instret)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit follow = 1'b0;

    // Reference model: 0 = boot, 1 = run, 2 = halt
    int          m_mode;
    logic        m_trap;
    logic [31:0] m_epc, m_instret;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [32:0] model_comb();
        logic [31:0] tgt;
        tgt = jump ? jump_target : branch_target;
        if (rst || m_mode == 0) return {1'b1, RV};
        if (m_mode == 2 || halt_req || stall) return {1'b0, pc};
        if (jump || branch_taken) return {1'b1, (tgt % 4 != 0) ? TV : tgt};
        return {1'b1, pc + 32'd4};
    endfunction

    task automatic step(input string nm);
        logic [32:0] e;
        int          n_mode;
        logic        n_trap;
        logic [31:0] n_epc, n_inst, tgt;
        #1;
        e = model_comb();
        chk({nm, ".PCNext"}, PCNext, e[31:0]);
        chk({nm, ".pc_en"}, {31'd0, pc_en}, {31'd0, e[32]});
        tgt = jump ? jump_target : branch_target;
        if (rst) begin
            n_mode = 0; n_trap = 0; n_epc = 0; n_inst = 0;
        end else begin
            n_trap = (m_mode == 1) && !halt_req && !stall && (jump || branch_taken) && (tgt % 4 != 0);
            n_epc  = n_trap ? pc : m_epc;
            n_inst = m_instret + ((m_mode == 1 && e[32]) ? 32'd1 : 32'd0);
            if (m_mode == 0) n_mode = 1;
            else if (m_mode == 1) n_mode = halt_req ? 2 : 1;
            else n_mode = (resume && !halt_req) ? 1 : 2;
        end
        @(posedge clk);
        #1;
        m_mode = n_mode; m_trap = n_trap; m_epc = n_epc; m_instret = n_inst;
        chk({nm, ".state"}, {30'd0, state}, m_mode);
        chk({nm, ".trap"}, {31'd0, trap}, {31'd0, m_trap});
        chk({nm, ".epc"}, epc, m_epc);
        chk({nm, ".instret"}, instret, m_instret);
        if (follow && e[32]) pc = e[31:0];
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 0; branch_taken = 0; jump = 0; halt_req = 0; resume = 0;
        branch_target = 0; jump_target = 0;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic [31:0] exp_nx;
        logic        exp_en;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] inst_before;
        tbl[0] = '{32'h10, 0, 1, 32'h40, 0, 32'h0,  32'h40,  1};
        tbl[1] = '{32'h10, 0, 1, 32'h40, 1, 32'h80, 32'h80,  1};
        tbl[2] = '{32'h20, 0, 0, 32'h0,  1, 32'h22, 32'h100, 1};
        tbl[3] = '{32'h24, 0, 0, 32'h0,  0, 32'h0,  32'h28,  1};
        tbl[4] = '{32'h30, 1, 1, 32'h60, 0, 32'h0,  32'h30,  0};
        tbl[5] = '{32'h30, 1, 1, 32'h60, 0, 32'h0,  32'h30,  0};
        tbl[6] = '{32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1};
        tbl[7] = '{32'h44, 0, 1, 32'h41, 0, 32'h0,  32'h100, 1};
        tbl[8] = '{32'h48, 0, 1, 32'h4C, 1, 32'h63, 32'h100, 1};

        m_mode = 0; m_trap = 0; m_epc = 0; m_instret = 0;
        idle_inputs();
        pc = 0;
        rst = 1;
        @(negedge clk);
        step("reset0");
        step("reset1");
        chk("reset.state", {30'd0, state}, 32'd0);
        chk("reset.trap", {31'd0, trap}, 32'd0);
        chk("reset.instret", instret, 32'd0);

        rst = 0;
        follow = 1;
        #1;
        chk("boot.PCNext", PCNext, RV);
        chk("boot.state", {30'd0, state}, 32'd0);
        step("boot");
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk("seq.PCNext", PCNext, 32'(4 * i));
            step("seq");
            chk("seq.instret", instret, 32'(i));
        end

        follow = 0;
        for (int i = 0; i < 9; i++) begin
            pc = tbl[i].pc; stall = tbl[i].stall;
            branch_taken = tbl[i].br; branch_target = tbl[i].bt;
            jump = tbl[i].jmp; jump_target = tbl[i].jt;
            inst_before = instret;
            #1;
            chk($sformatf("tbl%0d.PCNext", i), PCNext, tbl[i].exp_nx);
            chk($sformatf("tbl%0d.pc_en", i), {31'd0, pc_en}, {31'd0, tbl[i].exp_en});
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.instret_delta", i), instret - inst_before, {31'd0, tbl[i].exp_en});
            if (i == 2) begin
                chk("trap.pulse", {31'd0, trap}, 32'd1);
                chk("trap.epc", epc, 32'h20);
            end
            if (i == 3) chk("trap.cleared", {31'd0, trap}, 32'd0);
        end

        idle_inputs();
        pc = 32'h50; halt_req = 1;
        step("halt_enter");
        chk("halt.state", {30'd0, state}, 32'd2);
        halt_req = 0;
        for (int i = 0; i < 3; i++) begin
            jump = i[0]; jump_target = 32'h200; stall = ~i[0];
            #1;
            chk("halt.pc_en", {31'd0, pc_en}, 32'd0);
            step("halt_hold");
            chk("halt.hold_state", {30'd0, state}, 32'd2);
        end
        idle_inputs();
        halt_req = 1; resume = 1;
        step("halt_both");
        chk("halt.both_state", {30'd0, state}, 32'd2);
        halt_req = 0;
        step("resume");
        chk("resume.state", {30'd0, state}, 32'd1);
        resume = 0;
        #1;
        chk("resume.PCNext", PCNext, 32'h54);
        step("resume_seq");

        pc = 32'h60; jump = 1; jump_target = 32'h71;
        step("trap_then_rst");
        chk("trap2.pulse", {31'd0, trap}, 32'd1);
        idle_inputs();
        rst = 1;
        #1;
        chk("rst_mid.PCNext", PCNext, RV);
        step("rst_mid");
        chk("rst_mid.trap", {31'd0, trap}, 32'd0);
        chk("rst_mid.state", {30'd0, state}, 32'd0);
        rst = 0;
        #1;
        chk("reboot.PCNext", PCNext, RV);
        step("reboot");

        follow = 1;
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom % 150) == 0;
            stall        = ($urandom % 5) == 0;
            halt_req     = ($urandom % 15) == 0;
            resume       = ($urandom % 4) == 0;
            jump         = ($urandom % 6) == 0;
            branch_taken = ($urandom % 5) == 0;
            jump_target   = (($urandom % 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            branch_target = (($urandom % 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            if (($urandom % 25) == 0) pc = $urandom;
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
